// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared types, default geometry and an index-width helper for
//               the banked RAM and its bank sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  // Controller states: CLEAR zeroes the array row by row, IDLE serves accesses.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Default geometry matches the 64x16 RAM this block replaces.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_BANKS = 8;

  // Width of an index into n items. Never returns less than 1 so that a
  // single-entry dimension still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_banked_if.sv
// ============================================================================
// Module      : ram_banked_if
// Description : Access bus between a controller and the banked RAM.
//               master = controller side, slave = RAM side.
//   e     : chip enable            w     : write strobe
//   r     : read strobe            clr   : request a full-array clear
//   adr   : word address           din   : write data
//   dout  : registered read data   valid : dout holds fresh read data
//   busy  : clear sequence running, accesses ignored
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_banked_if
  import ram_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = idx_width(DEF_DEPTH)
);

  logic              e;
  logic              w;
  logic              r;
  logic              clr;
  logic [ADDR_W-1:0] adr;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic              valid;
  logic              busy;

  modport master (
    output e, w, r, clr, adr, din,
    input  dout, valid, busy
  );

  modport slave (
    input  e, w, r, clr, adr, din,
    output dout, valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/ram_bank.sv
// ============================================================================
// Module      : ram_bank
// Description : One bank of ROWS x WIDTH storage. Synchronous write gated by
//               bank enable and write enable; asynchronous read of the
//               addressed row so the top level can register it.
//   clk    : clock
//   en_i   : bank enable (this bank is the write target)
//   we_i   : write enable
//   row_i  : row address, shared by read and write
//   din_i  : write data
//   dout_o : combinational read data at row_i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_DEPTH / DEF_BANKS,
  parameter int ROW_W = idx_width(ROWS)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  // Storage is deliberately not reset; zeroing is done by the clear sequencer.
  logic [WIDTH-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[row_i] <= din_i;
    end
  end

  // Read sees the pre-edge contents, which gives read-first behaviour when a
  // read and a write hit the same row in one cycle.
  assign dout_o = mem_q[row_i];

endmodule

`default_nettype wire

// File: rtl/ram_banked.sv
// ============================================================================
// Module      : ram_banked
// Description : Parametrised banked single-port RAM with registered read data,
//               a one-cycle valid strobe and a hardware clear sequencer that
//               zeroes every word after reset or on a clr request.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : ram_banked_if slave port (e, w, r, clr, adr, din / dout, valid, busy)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BANKS = DEF_BANKS
) (
  input  logic         clk,
  input  logic         rst,
  ram_banked_if.slave  bus
);

  localparam int ADDR_W = idx_width(DEPTH);
  localparam int BANK_W = idx_width(BANKS);
  localparam int ROWS   = DEPTH / BANKS;
  localparam int ROW_W  = idx_width(ROWS);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [ROW_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Address split: top BANK_W bits pick the bank, low ROW_W bits the row
  // --------------------------------------------------------------------------
  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  row_sel;

  assign bank_sel = bus.adr[ADDR_W-1 -: BANK_W];

  generate
    if (ROWS > 1) begin : g_row_multi
      assign row_sel = bus.adr[ROW_W-1:0];
    end else begin : g_row_single
      assign row_sel = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bank control
  // --------------------------------------------------------------------------
  logic             clearing;
  logic             access;
  logic             wr_req;
  logic [BANKS-1:0] bank_en;
  logic             bank_we;
  logic [ROW_W-1:0] bank_row;
  logic [WIDTH-1:0] bank_din;
  logic [WIDTH-1:0] bank_rd [BANKS];
  logic [WIDTH-1:0] rd_word;

  // Memory is never written while rst is high, neither by the sequencer nor
  // by the controller.
  assign clearing = (state_q == CLEAR) && !rst;
  assign access   = (state_q == IDLE) && bus.e && !rst;
  assign wr_req   = access && bus.w;

  // While clearing, every bank writes zero to the same row in parallel.
  assign bank_we  = clearing || wr_req;
  assign bank_row = clearing ? cnt_q : row_sel;
  assign bank_din = clearing ? '0 : bus.din;

  // One-hot bank decode for normal writes, all banks during clear.
  always_comb begin
    bank_en = '0;
    if (clearing) begin
      bank_en = '1;
    end else if (wr_req) begin
      bank_en[bank_sel] = 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
      ram_bank #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
      ) u_bank (
        .clk    (clk),
        .en_i   (bank_en[g]),
        .we_i   (bank_we),
        .row_i  (bank_row),
        .din_i  (bank_din),
        .dout_o (bank_rd[g])
      );
    end
  endgenerate

  // Output mux, indexed by the bank bits of the address.
  assign rd_word = bank_rd[bank_sel];

  // --------------------------------------------------------------------------
  // FSM: next state, clear counter and output registers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;

    case (state_q)
      CLEAR: begin
        // Accesses and clr are ignored; dout holds its value.
        if (cnt_q == LAST_ROW) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + ROW_W'(1);
        end
      end

      IDLE: begin
        // A read issued together with clr is still serviced.
        if (bus.e && bus.r) begin
          dout_d  = rd_word;
          valid_d = 1'b1;
        end
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == CLEAR);

endmodule

`default_nettype wire
